// File: rtl/fifod2mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifod2mac_pkg
// Brief    : State encodings and frame header constants for fifod2mac.
// Revision : 1.0  initial release
// ============================================================================
package fifod2mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [11:0] C_HDR_LEN   = 12'd4;
    localparam logic [7:0]  C_SYNC0_DEF = 8'h55;
    localparam logic [7:0]  C_SYNC1_DEF = 8'hAA;

    // A frame always carries at least the full header.
    function automatic logic [11:0] clamp_len(input logic [11:0] len);
        return (len < C_HDR_LEN) ? C_HDR_LEN : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifod2mac.sv
`default_nettype none
// ============================================================================
// Module   : fifod2mac
// Brief    : Drains fifod bytes into the mac UDP payload, prefixed by a
//            4-byte header (sync, sync, sequence, device info).
// Revision : 1.0  initial release
// ============================================================================
module fifod2mac
    import fifod2mac_pkg::*;
#(
    parameter logic [7:0]  SYNC0        = C_SYNC0_DEF,
    parameter logic [7:0]  SYNC1        = C_SYNC1_DEF,
    parameter logic [15:0] PREP_TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    output logic        err,
    input  logic [11:0] tx_len,
    input  logic [7:0]  dev_info,
    output logic        fifod_rxen,
    input  logic [7:0]  fifod_rxd,
    input  logic        fifod_empty,
    output logic        flag_udp_tx_req,
    input  logic        flag_udp_tx_prep,
    input  logic        udp_txen,
    output logic [7:0]  udp_txd
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_len;
    logic [11:0] r_bcnt;
    logic [7:0]  r_seq;
    logic [15:0] r_tocnt;
    logic        r_err;
    logic [7:0]  r_txd;
    logic        r_sel_fifo;

    logic        w_serve;
    logic        w_hdr;
    logic        w_rd;
    logic        w_last;
    logic        w_timeout;
    logic [7:0]  w_hdr_byte;

    always_comb begin
        w_serve     = (r_state == ST_STREAM) && udp_txen && (r_bcnt < r_len);
        w_hdr       = (r_bcnt < C_HDR_LEN);
        // Gated by rst so the reset edge can never pop a byte out of fifod.
        w_rd        = w_serve && !w_hdr && !fifod_empty && !rst;
        w_last      = w_serve && (r_bcnt == (r_len - 12'd1));
        w_timeout   = (r_state == ST_REQ) && !flag_udp_tx_prep &&
                      (r_tocnt == (PREP_TIMEOUT - 16'd1));
        w_hdr_byte  = 8'h00;
        case (r_bcnt[1:0])
            2'd0:    w_hdr_byte = SYNC0;
            2'd1:    w_hdr_byte = SYNC1;
            2'd2:    w_hdr_byte = r_seq;
            default: w_hdr_byte = dev_info;
        endcase

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (fs) w_state_nxt = ST_REQ;
            ST_REQ:    if (flag_udp_tx_prep) w_state_nxt = ST_STREAM;
                       else if (w_timeout)   w_state_nxt = ST_DONE;
            ST_STREAM: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:   if (!fs) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len      <= C_HDR_LEN;
            r_bcnt     <= 12'd0;
            r_seq      <= 8'd0;
            r_tocnt    <= 16'd0;
            r_err      <= 1'b0;
            r_txd      <= 8'd0;
            r_sel_fifo <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Data bytes bypass r_txd and come straight from fifod's read port.
            r_sel_fifo <= w_rd;
            r_txd      <= (w_serve && w_hdr) ? w_hdr_byte : 8'd0;
            case (r_state)
                ST_IDLE: begin
                    if (fs) begin
                        r_len   <= clamp_len(tx_len);
                        r_err   <= 1'b0;
                        r_bcnt  <= 12'd0;
                        r_tocnt <= 16'd0;
                    end
                end
                ST_REQ: begin
                    r_tocnt <= r_tocnt + 16'd1;
                    if (w_timeout) r_err <= 1'b1;
                end
                ST_STREAM: begin
                    if (w_serve) begin
                        r_bcnt <= r_bcnt + 12'd1;
                        if (!w_hdr && fifod_empty) r_err <= 1'b1;
                        if (w_last) r_seq <= r_seq + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fd              = (r_state == ST_DONE);
    assign flag_udp_tx_req = (r_state == ST_REQ);
    assign fifod_rxen      = w_rd;
    assign err             = r_err;
    assign udp_txd         = r_sel_fifo ? fifod_rxd : r_txd;

endmodule
`default_nettype wire

// File: tb/tb_fifod2mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifod2mac
// Brief    : Directed, table-driven bench for fifod2mac with a fifod model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifod2mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        fd;
    logic        err;
    logic [11:0] tx_len;
    logic [7:0]  dev_info;
    logic        fifod_rxen;
    logic [7:0]  fifod_rxd;
    logic        fifod_empty;
    logic        flag_udp_tx_req;
    logic        flag_udp_tx_prep;
    logic        udp_txen;
    logic [7:0]  udp_txd;

    fifod2mac dut (
        .clk              (clk),
        .rst              (rst),
        .fs               (fs),
        .fd               (fd),
        .err              (err),
        .tx_len           (tx_len),
        .dev_info         (dev_info),
        .fifod_rxen       (fifod_rxen),
        .fifod_rxd        (fifod_rxd),
        .fifod_empty      (fifod_empty),
        .flag_udp_tx_req  (flag_udp_tx_req),
        .flag_udp_tx_prep (flag_udp_tx_prep),
        .udp_txen         (udp_txen),
        .udp_txd          (udp_txd)
    );

    always #5 clk = ~clk;

    // fifod model: 1-cycle read latency; writes from the stimulus, reads here.
    logic [7:0] fmem [0:255];
    int         wp = 0;
    int         rp = 0;
    int         reads = 0;
    assign fifod_empty = (wp == rp);

    initial fifod_rxd = 8'h00;
    always @(posedge clk) begin
        if (fifod_rxen) begin
            fifod_rxd <= fmem[rp[7:0]];
            rp        <= rp + 1;
            reads     <= reads + 1;
        end
    end

    typedef struct {
        logic       txen;
        logic       rxen;
        logic [7:0] txd;
    } vec_t;

    vec_t vq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wp[7:0]] = b;
        wp++;
    endtask

    task automatic add_vec(input logic t, input logic r, input logic [7:0] d);
        vec_t v;
        v.txen = t; v.rxen = r; v.txd = d;
        vq.push_back(v);
    endtask

    task automatic add_hdr(input logic [7:0] seq, input logic [7:0] dev);
        add_vec(1'b1, 1'b0, 8'h55);
        add_vec(1'b1, 1'b0, 8'hAA);
        add_vec(1'b1, 1'b0, seq);
        add_vec(1'b1, 1'b0, dev);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            udp_txen = vq[i].txen;
            #1;
            chk($sformatf("%s rxen[%0d]", tag, i), {31'd0, fifod_rxen}, {31'd0, vq[i].rxen});
            @(posedge clk); #1;
            chk($sformatf("%s txd[%0d]", tag, i), {24'd0, udp_txd}, {24'd0, vq[i].txd});
        end
        udp_txen = 1'b0;
        vq.delete();
    endtask

    task automatic start_frame(input logic [11:0] len, input logic [7:0] dev, input int delay);
        tx_len   = len;
        dev_info = dev;
        fs       = 1'b1;
        @(posedge clk); #1;
        chk("req after fs", {31'd0, flag_udp_tx_req}, 32'd1);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        flag_udp_tx_prep = 1'b1;
        @(posedge clk); #1;
        flag_udp_tx_prep = 1'b0;
        chk("req drop on prep", {31'd0, flag_udp_tx_req}, 32'd0);
    endtask

    task automatic finish_frame(input logic exp_err);
        int n = 0;
        while (fd !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("fd raised", {31'd0, fd}, 32'd1);
        chk("err at done", {31'd0, err}, {31'd0, exp_err});
        fs = 1'b0;
        @(posedge clk); #1;
        chk("fd cleared", {31'd0, fd}, 32'd0);
    endtask

    initial begin
        int r0;
        int n;
        rst = 1'b1; fs = 1'b0; tx_len = 12'd0; dev_info = 8'h00;
        flag_udp_tx_prep = 1'b0; udp_txen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst fd", {31'd0, fd}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst req", {31'd0, flag_udp_tx_req}, 32'd0);
        chk("rst rxen", {31'd0, fifod_rxen}, 32'd0);
        chk("rst txd", {24'd0, udp_txd}, 32'd0);
        rst = 1'b0;

        // Basic frame: 12 bytes, 8 from fifod.
        for (int i = 1; i <= 8; i++) push(i[7:0]);
        r0 = reads;
        start_frame(12'd12, 8'h3C, 3);
        add_hdr(8'h00, 8'h3C);
        for (int i = 1; i <= 8; i++) add_vec(1'b1, 1'b1, i[7:0]);
        run_vecs("t1");
        chk("t1 reads", reads - r0, 32'd8);
        finish_frame(1'b0);

        // Sequence number walks through a full wrap.
        for (int f = 1; f <= 256; f++) begin
            start_frame(12'd4, 8'h3C, 0);
            add_hdr(f[7:0], 8'h3C);
            run_vecs("t2");
            finish_frame(1'b0);
        end

        // Underflow: 3 data bytes available for 6 requested.
        push(8'hA1); push(8'hA2); push(8'hA3);
        r0 = reads;
        start_frame(12'd10, 8'h3C, 1);
        add_hdr(8'h01, 8'h3C);
        add_vec(1'b1, 1'b1, 8'hA1);
        add_vec(1'b1, 1'b1, 8'hA2);
        add_vec(1'b1, 1'b1, 8'hA3);
        for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b0, 8'h00);
        run_vecs("t3");
        chk("t3 reads", reads - r0, 32'd3);
        finish_frame(1'b1);

        // Paused requests and surplus requests past the end of frame.
        for (int i = 1; i <= 4; i++) push(8'hB0 + i[7:0]);
        r0 = reads;
        start_frame(12'd8, 8'h3C, 0);
        add_hdr(8'h02, 8'h3C);
        for (int i = 1; i <= 4; i++) begin
            add_vec(1'b1, 1'b1, 8'hB0 + i[7:0]);
            if (i < 4) add_vec(1'b0, 1'b0, 8'h00);
        end
        add_vec(1'b1, 1'b0, 8'h00);
        add_vec(1'b1, 1'b0, 8'h00);
        run_vecs("t4");
        chk("t4 reads", reads - r0, 32'd4);
        chk("t4 fifo drained", {31'd0, fifod_empty}, 32'd1);
        finish_frame(1'b0);

        // Prep never arrives: timeout after exactly 50000 request cycles.
        r0 = reads;
        tx_len = 12'd12;
        fs = 1'b1;
        @(posedge clk); #1;
        chk("t5 req", {31'd0, flag_udp_tx_req}, 32'd1);
        n = 0;
        while (fd !== 1'b1 && n < 60000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5 timeout cycles", n, 32'd50000);
        chk("t5 req low", {31'd0, flag_udp_tx_req}, 32'd0);
        chk("t5 reads", reads - r0, 32'd0);
        finish_frame(1'b1);

        // Short tx_len is stretched to the header only.
        start_frame(12'd2, 8'h3C, 0);
        add_hdr(8'h03, 8'h3C);
        add_vec(1'b1, 1'b0, 8'h00);
        run_vecs("t5b");
        finish_frame(1'b0);

        // Reset in the middle of the data phase.
        for (int i = 1; i <= 8; i++) push(8'hC0 + i[7:0]);
        r0 = reads;
        start_frame(12'd12, 8'h3C, 1);
        add_hdr(8'h04, 8'h3C);
        add_vec(1'b1, 1'b1, 8'hC1);
        add_vec(1'b1, 1'b1, 8'hC2);
        run_vecs("t6");
        udp_txen = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6 no read on rst edge", {31'd0, fifod_rxen}, 32'd0);
        @(posedge clk); #1;
        chk("t6 fd", {31'd0, fd}, 32'd0);
        chk("t6 err", {31'd0, err}, 32'd0);
        chk("t6 req", {31'd0, flag_udp_tx_req}, 32'd0);
        chk("t6 rxen", {31'd0, fifod_rxen}, 32'd0);
        chk("t6 txd", {24'd0, udp_txd}, 32'd0);
        chk("t6 reads", reads - r0, 32'd2);
        rst = 1'b0;
        udp_txen = 1'b0;
        fs = 1'b0;
        wp = rp;
        @(posedge clk); #1;
        start_frame(12'd4, 8'h3C, 0);
        add_hdr(8'h00, 8'h3C);
        run_vecs("t6b");
        finish_frame(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
